// File: rtl/uncached_axi_bridge.sv
// Uncached data-port bridge: turns one translated CPU load/store into a
// single-beat AXI4 read or write, one access outstanding at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a CPU request
// RD_ADDR | presenting the read address until arready
// RD_DATA | waiting for the read beat, captured into rdata_o
// WR_REQ  | presenting AW and W, each dropped after its own handshake
// WR_RESP | waiting for the write response
module uncached_axi_bridge #(
   parameter logic [3:0] AXI_ID = 4'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic [3:0]  arid_o,
   output logic [31:0] araddr_o,
   output logic [2:0]  arsize_o,
   output logic        arvalid_o,
   input  logic        arready_i,
   input  logic [31:0] rdata_i,
   input  logic [1:0]  rresp_i,
   input  logic        rlast_i,
   input  logic        rvalid_i,
   output logic        rready_o,
   output logic [3:0]  awid_o,
   output logic [31:0] awaddr_o,
   output logic [2:0]  awsize_o,
   output logic        awvalid_o,
   input  logic        awready_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic        wlast_o,
   output logic        wvalid_o,
   input  logic        wready_i,
   input  logic [1:0]  bresp_i,
   input  logic        bvalid_i,
   output logic        bready_o
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

   state_t      state, state_nxt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  sel_q;
   logic        we_q;
   logic        aw_done, w_done;
   logic [2:0]  size;
   logic        accept;
   logic        aw_hs, w_hs;

   // Responses and the registered direction are not needed for completion;
   // errors are not reported back to the CPU on this path.
   logic unused_inputs;
   assign unused_inputs = ^{rresp_i, rlast_i, bresp_i, we_q};

   assign accept = (state == IDLE) && req_i && !ack_o;
   assign aw_hs  = awvalid_o && awready_i;
   assign w_hs   = wvalid_o && wready_i;

   assign busy_o   = (state != IDLE);
   assign arid_o   = AXI_ID;
   assign awid_o   = AXI_ID;
   assign araddr_o = addr_q;
   assign awaddr_o = addr_q;
   assign arsize_o = size;
   assign awsize_o = size;
   assign wdata_o  = wdata_q;
   assign wstrb_o  = sel_q;
   assign wlast_o  = wvalid_o;

   // Transfer size from the byte enables: single byte, aligned halfword, else word.
   always_comb begin
      size = 3'd2;
      case (sel_q)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
         4'b0011, 4'b1100:                   size = 3'd1;
         default:                            size = 3'd2;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and AXI valid/ready outputs.
   always_comb begin
      state_nxt = state;
      arvalid_o = 1'b0;
      rready_o  = 1'b0;
      awvalid_o = 1'b0;
      wvalid_o  = 1'b0;
      bready_o  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = we_i ? WR_REQ : RD_ADDR;
         end
         RD_ADDR: begin
            arvalid_o = 1'b1;
            if (arready_i) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            rready_o = 1'b1;
            if (rvalid_i) state_nxt = IDLE;
         end
         WR_REQ: begin
            awvalid_o = !aw_done;
            wvalid_o  = !w_done;
            if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            bready_o = 1'b1;
            if (bvalid_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture and per-channel write handshake tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (accept) begin
         addr_q  <= addr_i;
         wdata_q <= wdata_i;
         sel_q   <= sel_i;
         we_q    <= we_i;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (state == WR_REQ) begin
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
      end
   end

   // Completion pulse and load data; stores leave rdata_o untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_o   <= 1'b0;
         rdata_o <= '0;
      end else begin
         ack_o <= ((state == RD_DATA) && rvalid_i) || ((state == WR_RESP) && bvalid_i);
         if ((state == RD_DATA) && rvalid_i) rdata_o <= rdata_i;
      end
   end

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Bench for uncached_axi_bridge: a timeline model predicts, for each access,
// which cycle every valid/ready/ack is high given the slave's wait counts.
module tb_uncached_axi_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i, we_i;
   logic [3:0]  sel_i;
   logic [31:0] addr_i, wdata_i;
   logic        ack_o;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic [3:0]  arid_o, awid_o;
   logic [31:0] araddr_o, awaddr_o;
   logic [2:0]  arsize_o, awsize_o;
   logic        arvalid_o, arready_i;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i, bresp_i;
   logic        rlast_i, rvalid_i, rready_o;
   logic        awvalid_o, awready_i;
   logic [31:0] wdata_o;
   logic [3:0]  wstrb_o;
   logic        wlast_o, wvalid_o, wready_i;
   logic        bvalid_i, bready_o;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_rd = 32'h0;

   always #5 clk = ~clk;

   uncached_axi_bridge #(.AXI_ID(4'h1)) dut (
      .clk(clk), .rst(rst),
      .req_i(req_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .ack_o(ack_o), .rdata_o(rdata_o), .busy_o(busy_o),
      .arid_o(arid_o), .araddr_o(araddr_o), .arsize_o(arsize_o),
      .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
      .rvalid_i(rvalid_i), .rready_o(rready_o),
      .awid_o(awid_o), .awaddr_o(awaddr_o), .awsize_o(awsize_o),
      .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
      .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
   );

   function automatic logic [2:0] exp_size(input logic [3:0] s);
      if ($countones(s) == 1)              return 3'd0;
      else if (s == 4'b0011 || s == 4'b1100) return 3'd1;
      else                                 return 3'd2;
   endfunction

   // Slave response inputs idle (no handshakes offered).
   task automatic slave_idle();
      arready_i = 1'b0; rvalid_i = 1'b0; awready_i = 1'b0;
      wready_i  = 1'b0; bvalid_i = 1'b0;
      rdata_i = $urandom; rresp_i = 2'($urandom); bresp_i = 2'($urandom);
      rlast_i = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_i = 1'b0; we_i = 1'b0; sel_i = 4'h0; addr_i = '0; wdata_i = '0;
      slave_idle();
      repeat (2) @(negedge clk);
      checks++;
      if ({ack_o, busy_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctl got=%b exp=0000000",
                  {ack_o, busy_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o});
      end
      checks++;
      if (rdata_o !== 32'h0) begin
         failures++; $display("FAIL reset_rdata got=%h exp=00000000", rdata_o);
      end
      rst = 1'b0;
      last_rd = 32'h0;
   endtask

   // One load; arw/rw = cycles arready/rvalid are held low by the slave.
   task automatic test_read(input logic [31:0] a, input logic [3:0] s, input logic [31:0] rv,
                            input int arw, input int rw, input bit spur, input bit keep);
      int ack_k;
      logic [6:0] got, expv;
      logic [31:0] rexp;
      ack_k = 3 + arw + rw;
      for (int k = 0; k <= ack_k; k++) begin
         @(negedge clk);
         got  = {arvalid_o, rready_o, ack_o, busy_o, awvalid_o, wvalid_o, bready_o};
         expv = {(k >= 1 && k <= 1 + arw), (k >= 2 + arw && k <= 2 + arw + rw),
                 (k == ack_k), (k >= 1 && k < ack_k), 3'b000};
         checks++;
         if (got !== expv) begin
            failures++; $display("FAIL rd_ctl k=%0d got=%b exp=%b", k, got, expv);
         end
         if (arvalid_o) begin
            checks++;
            if ({araddr_o, arsize_o, arid_o} !== {a, exp_size(s), 4'h1}) begin
               failures++;
               $display("FAIL rd_addr k=%0d got=%h/%0d/%h exp=%h/%0d/1", k, araddr_o, arsize_o,
                        arid_o, a, exp_size(s));
            end
         end
         rexp = (k == ack_k) ? rv : last_rd;
         checks++;
         if (rdata_o !== rexp) begin
            failures++; $display("FAIL rd_data k=%0d got=%h exp=%h", k, rdata_o, rexp);
         end
         if (k == 0) begin
            req_i = 1'b1; we_i = 1'b0; sel_i = s; addr_i = a; wdata_i = $urandom;
         end
         slave_idle();
         arready_i = (k == 1 + arw);
         rvalid_i  = (k == 2 + arw + rw);
         if (rvalid_i) rdata_i = rv;
         bvalid_i  = spur && (($urandom & 1) != 0);
         if (k == ack_k) begin
            req_i = keep;
            slave_idle();
         end
      end
      last_rd = rv;
   endtask

   // One store; aww/ww/bw = cycles awready/wready/bvalid are held low.
   task automatic test_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                             input int aww, input int ww, input int bw, input bit spur,
                             input bit keep);
      int m, ack_k;
      logic [6:0] got, expv;
      m = (aww > ww) ? aww : ww;
      ack_k = 3 + m + bw;
      for (int k = 0; k <= ack_k; k++) begin
         @(negedge clk);
         got  = {arvalid_o, rready_o, ack_o, busy_o, awvalid_o, wvalid_o, bready_o};
         expv = {2'b00, (k == ack_k), (k >= 1 && k < ack_k), (k >= 1 && k <= 1 + aww),
                 (k >= 1 && k <= 1 + ww), (k >= 2 + m && k <= 2 + m + bw)};
         checks++;
         if (got !== expv) begin
            failures++; $display("FAIL wr_ctl k=%0d got=%b exp=%b", k, got, expv);
         end
         if (awvalid_o) begin
            checks++;
            if ({awaddr_o, awsize_o, awid_o} !== {a, exp_size(s), 4'h1}) begin
               failures++;
               $display("FAIL wr_addr k=%0d got=%h/%0d/%h exp=%h/%0d/1", k, awaddr_o, awsize_o,
                        awid_o, a, exp_size(s));
            end
         end
         if (wvalid_o) begin
            checks++;
            if ({wdata_o, wstrb_o, wlast_o} !== {wd, s, 1'b1}) begin
               failures++;
               $display("FAIL wr_data k=%0d got=%h/%b/%b exp=%h/%b/1", k, wdata_o, wstrb_o,
                        wlast_o, wd, s);
            end
         end
         checks++;
         if (rdata_o !== last_rd) begin
            failures++; $display("FAIL wr_rdata_held k=%0d got=%h exp=%h", k, rdata_o, last_rd);
         end
         if (k == 0) begin
            req_i = 1'b1; we_i = 1'b1; sel_i = s; addr_i = a; wdata_i = wd;
         end
         slave_idle();
         awready_i = (k == 1 + aww);
         wready_i  = (k == 1 + ww);
         bvalid_i  = (k == 2 + m + bw);
         rvalid_i  = spur && (($urandom & 1) != 0);
         if (k == ack_k) begin
            req_i = keep;
            slave_idle();
         end
      end
   endtask

   // Reset asserted while waiting for read data abandons the access at once.
   task automatic test_reset_mid();
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; addr_i = $urandom; slave_idle();
      @(negedge clk);
      arready_i = 1'b1;
      @(negedge clk);
      arready_i = 1'b0;
      checks++;
      if (rready_o !== 1'b1) begin
         failures++; $display("FAIL rst_mid_pre rready got=%b exp=1", rready_o);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({rready_o, ack_o, busy_o, arvalid_o} !== 4'b0) begin
         failures++;
         $display("FAIL rst_mid_ctl got=%b exp=0000", {rready_o, ack_o, busy_o, arvalid_o});
      end
      checks++;
      if (rdata_o !== 32'h0) begin
         failures++; $display("FAIL rst_mid_rdata got=%h exp=00000000", rdata_o);
      end
      req_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_rd = 32'h0;
      test_read(32'h1FC0_0012, 4'b0011, $urandom, 0, 0, 1'b0, 1'b0);
   endtask

   // Request held high across ack: the next access starts the cycle after.
   task automatic test_back_to_back();
      test_read(32'h1FAF_0004, 4'hF, 32'h1234_5678, 0, 0, 1'b0, 1'b1);
      test_write(32'h1FAF_0008, 4'b1100, 32'hCAFE_0000, 0, 0, 0, 1'b0, 1'b1);
      test_read(32'h1FAF_000C, 4'b0100, 32'h0055_0000, 1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [3:0] s;
      for (int i = 0; i < 40; i++) begin
         s = 4'($urandom_range(1, 15));
         if (($urandom & 1) != 0)
            test_write($urandom, s, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 2), 1'b1, ($urandom & 1) != 0);
         else
            test_read($urandom, s, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'b1, ($urandom & 1) != 0);
      end
      @(negedge clk);
      req_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read(32'h1FAF_F000, 4'hF, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
      test_write(32'h1FD0_1003, 4'b1000, 32'hAB00_0000, 0, 0, 0, 1'b0, 1'b0);
      test_write(32'h1FD0_2000, 4'hF, 32'h0BAD_F00D, 3, 0, 0, 1'b0, 1'b0);
      test_read(32'h1FAF_F100, 4'b0010, 32'h0000_7700, 2, 2, 1'b1, 1'b0);
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
